// File: rtl/subleq_pkg.sv
// Shared definitions for the Subleq sequencer: state encoding, instruction
// length and the halt-address rule.
package subleq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WRITE,
    S_HALT
  } state_t;

  localparam int unsigned INSN_WORDS = 3;

  // A branch target with every one of its addr_w low bits set means "halt".
  function automatic logic is_halt_addr(input logic [31:0] c, input int unsigned addr_w);
    logic [31:0] mask;
    mask = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
    return (c & mask) == mask;
  endfunction

endpackage

// File: rtl/subleq_seq.sv
// Subleq instruction sequencer: fetches A/B/C, loads operands, drives the
// external subtract/flag ALU and writes mem[B] back, then branches.
module subleq_seq
  import subleq_pkg::*;
#(
  parameter int unsigned P_DATA     = 8,
  parameter int unsigned P_ADDR     = 8,
  parameter int unsigned P_RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              halted,
  output logic              mem_req,
  output logic              mem_we,
  output logic [P_ADDR-1:0] mem_addr,
  output logic [P_DATA-1:0] mem_wdata,
  input  logic [P_DATA-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [P_DATA-1:0] alu_a,
  output logic [P_DATA-1:0] alu_b,
  input  logic [P_DATA-1:0] alu_r,
  input  logic              alu_z,
  output logic [P_ADDR-1:0] pc
);

  state_t              r_state;
  state_t              w_next;
  logic [P_ADDR-1:0]   r_pc;
  logic [P_ADDR-1:0]   r_a;
  logic [P_ADDR-1:0]   r_b;
  logic [P_ADDR-1:0]   r_c;
  logic [P_DATA-1:0]   r_opa;
  logic [P_DATA-1:0]   r_opb;
  logic [P_DATA-1:0]   r_res;
  logic                r_zf;
  logic [P_ADDR-1:0]   w_rd_addr;
  logic                w_halt_tgt;

  // Fetched words become addresses: truncated or zero-extended to P_ADDR.
  assign w_rd_addr  = P_ADDR'(mem_rdata);
  assign w_halt_tgt = r_zf && is_halt_addr(32'(r_c), P_ADDR);

  assign halted = (r_state == S_HALT);
  assign alu_a  = r_opb;
  assign alu_b  = r_opa;
  assign pc     = r_pc;

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH_A;
      end
      S_FETCH_A: begin
        mem_req  = 1'b1;
        mem_addr = r_pc;
        if (mem_ack) w_next = S_FETCH_B;
      end
      S_FETCH_B: begin
        mem_req  = 1'b1;
        mem_addr = r_pc + P_ADDR'(1);
        if (mem_ack) w_next = S_FETCH_C;
      end
      S_FETCH_C: begin
        mem_req  = 1'b1;
        mem_addr = r_pc + P_ADDR'(2);
        if (mem_ack) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        mem_req  = 1'b1;
        mem_addr = r_a;
        if (mem_ack) w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        mem_req  = 1'b1;
        mem_addr = r_b;
        if (mem_ack) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_b;
        mem_wdata = r_res;
        if (mem_ack) w_next = w_halt_tgt ? S_HALT : S_FETCH_A;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= P_ADDR'(P_RESET_PC);
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_zf    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH_A: if (mem_ack) r_a <= w_rd_addr;
        S_FETCH_B: if (mem_ack) r_b <= w_rd_addr;
        S_FETCH_C: if (mem_ack) r_c <= w_rd_addr;
        S_LOAD_A:  if (mem_ack) r_opa <= mem_rdata;
        S_LOAD_B:  if (mem_ack) r_opb <= mem_rdata;
        S_EXEC: begin
          // Branch follows the ALU's pre-wrap sign flag, not a test of r_res.
          r_res <= alu_r;
          r_zf  <= alu_z;
        end
        S_WRITE: begin
          if (mem_ack && !w_halt_tgt)
            r_pc <= r_zf ? r_c : r_pc + P_ADDR'(INSN_WORDS);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/subleq_seq.md
Name: subleq_seq

Overview:
- Instruction sequencer for the Subleq core. It drives the existing subtract/flag ALU and consumes its result.
- Executes `mem[B] = mem[B] - mem[A]`; if the result is <= 0, jumps to C, otherwise falls through to PC+3.
- Sits between a single-port word memory (req/ack handshake) and the ALU. It is the ALU's only operand source and result sink.

Parameters:
- P_DATA, 8, word width of memory data and ALU operands.
- P_ADDR, 8, PC/memory address width; addresses come from the low P_ADDR bits of fetched words.
- P_RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE and begins execution.
- halted  out  1  high while in HALT.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  P_ADDR  access address.
- mem_wdata  out  P_DATA  write data.
- mem_rdata  in  P_DATA  read data; valid in a cycle where mem_ack=1.
- mem_ack  in  1  access complete; sampled on the clk edge.
- alu_a  out  P_DATA  ALU minuend, always the registered mem[B].
- alu_b  out  P_DATA  ALU subtrahend, always the registered mem[A].
- alu_r  in  P_DATA  ALU difference.
- alu_z  in  1  ALU flag: signed difference <= 0.
- pc  out  P_ADDR  current instruction address.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; pc = P_RESET_PC.
  - All operand, result and address registers = 0.
  - mem_req, mem_we, halted = 0; mem_addr, mem_wdata, alu_a, alu_b = 0.
  - Reset during an in-flight access drops mem_req at once; the access is abandoned and no write completes from this block.
- States:
  - IDLE: start=1 -> FETCH_A.
  - FETCH_A, FETCH_B, FETCH_C: read addresses pc, pc+1, pc+2 (mod 2^P_ADDR). Store A, B, C.
  - LOAD_A: read mem[A] into opA.
  - LOAD_B: read mem[B] into opB.
  - EXEC: one cycle, no memory request. Capture alu_r into res and alu_z into zf.
  - WRITE: write res to mem[B].
  - HALT: terminal state.
- Memory state handshake:
  - mem_req=1 with mem_addr, mem_we and mem_wdata held stable until the edge where mem_ack=1.
  - On that edge the state advances (reads also latch mem_rdata).
  - Zero-wait memory (ack in the same cycle as req) gives one cycle per access.
  - mem_ack while in IDLE, EXEC or HALT is ignored.
- Latency:
  - Minimum 7 cycles per instruction (6 accesses + EXEC).
  - Each ack wait cycle adds 1 cycle.
- Branch, applied on the WRITE ack edge:
  - If zf=1 and C == all-ones (P_ADDR bits) -> HALT, halted=1.
  - Else if zf=1 -> pc = C.
  - Else pc = pc+3, wrapping modulo 2^P_ADDR (e.g. pc=254 with P_ADDR=8 gives 1). Then -> FETCH_A.
- Flag source:
  - The branch uses alu_z, never a recompute from res. The ALU evaluates the sign before wrap.
  - So an overflowing difference may wrap positive while zf=1; the sequencer follows zf.
- Word addresses:
  - A, B and C use the low P_ADDR bits of the fetched word. Upper bits are ignored when P_DATA > P_ADDR.
  - When P_ADDR > P_DATA, the fetched word is zero-extended.
- A == B is legal: mem[A] is written to 0 and zf=1.
- start outside IDLE is ignored. HALT is left only by rst.

Decomposition:
- Shared package `subleq_pkg`:
  - State enumeration (IDLE, FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, EXEC, WRITE, HALT).
  - Instruction length constant INSN_WORDS = 3.
  - Halt-address rule (all-ones C) as a function of P_ADDR.
- No sub-module inside this block.
- The ALU is instantiated beside it at core top level, with P_DATA matched and alu_a/alu_b/alu_r/alu_z connected point-to-point.

Test Plan (P_DATA=8, P_ADDR=8, zero-wait memory unless stated):
1. Basic fall-through:
   - mem[0..2]={9,10,40}, mem[9]=5, mem[10]=7, pulse start.
   - Required: mem[10]=2, pc=3, exactly 7 cycles from FETCH_A entry, halted=0.
2. Branch on zero:
   - Same program, mem[9]=7, mem[10]=7.
   - Required: mem[10]=0, pc=40.
3. Branch on negative:
   - mem[9]=100, mem[10]=50.
   - Required: mem[10]=8'hCE, pc=40.
4. Overflow flag:
   - mem[9]=100, mem[10]=8'h9C (-100).
   - Required: mem[10]=8'h38, zf=1, pc=40 (not 3).
5. Wait states and halt:
   - mem_ack delayed 2 cycles on every access; mem[0..2]={9,9,255}.
   - Required: mem_addr/mem_we/mem_wdata stable while waiting; 19 cycles for the instruction; mem[9]=0; halted=1; further start pulses ignored.
6. Wrap and reset mid-write:
   - P_RESET_PC=254, instruction at 254,255,0 with a positive result -> pc=1.
   - Then assert rst during WRITE with ack held low.
   - Required: mem_req=0 immediately, memory unchanged, pc=254, state IDLE.
